// File: rtl/rr_decoder_arbiter_pkg.sv
// Shared definitions for the round-robin decoder arbiter.
//   state_e        : arbiter FSM states (fixed encodings)
//   DefaultN       : default requester count
//   DefaultIdxW    : default select width, clog2(DefaultN)
package rr_decoder_arbiter_pkg;

  localparam int unsigned DefaultN    = 8;
  localparam int unsigned DefaultIdxW = 3;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StGrant = 2'd1,
    StGap   = 2'd2
  } state_e;

endpackage

// File: rtl/rr_decoder_arbiter_pick.sv
// Combinational rotate-priority picker.
// Scans req starting at ptr and wrapping (ptr, ptr+1, ..., N-1, 0, ..., ptr-1).
//   req  in  N      request vector
//   ptr  in  IDX_W  highest-priority index
//   any  out 1      at least one request set
//   idx  out IDX_W  index of the first set request in scan order (0 when any=0)
module rr_pick
  import rr_decoder_arbiter_pkg::*;
#(
  parameter int unsigned N     = DefaultN,
  parameter int unsigned IDX_W = DefaultIdxW
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int unsigned i = 0; i < N; i++) begin
      // N == 2**IDX_W, so the IDX_W-bit add wraps modulo N for free.
      cand = ptr + IDX_W'(i);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/rr_decoder_arbiter.sv
// Round-robin arbiter sharing one 3-to-8 one-hot decoder among N requesters.
// A grant is held until done from the owner, the owner dropping its request, or
// the hold limit expiring; each release is followed by one dead cycle.
//   clk           in   1      clock, all state on rising edge
//   rst           in   1      synchronous active-high reset
//   req           in   N      level requests
//   done          in   N      release pulses; only the granted bit is honoured
//   grant_valid   out  1      decoder enable
//   grant_idx     out  IDX_W  decoder select (holds last value when not valid)
//   grant_onehot  out  N      one-hot of grant_idx when valid, else zero
//   timeout_evt   out  1      one-cycle pulse on forced release
module rr_decoder_arbiter
  import rr_decoder_arbiter_pkg::*;
#(
  parameter int unsigned N        = DefaultN,
  parameter int unsigned IDX_W    = DefaultIdxW,
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     done,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx,
  output logic [N-1:0]     grant_onehot,
  output logic             timeout_evt
);

  localparam bit HasTimeout = (MAX_HOLD != 0);
  // With no timeout the counter just saturates at all-ones and is never compared.
  localparam logic [CNT_W-1:0] HoldLast = HasTimeout ? CNT_W'(MAX_HOLD - 1) : '1;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             valid_q, valid_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N-1:0]     onehot_q, onehot_d;
  logic             timeout_q, timeout_d;

  logic             pick_any;
  logic [IDX_W-1:0] pick_idx;
  logic             rel_done, rel_drop, rel_to;

  rr_pick #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_pick (
    .req (req),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    valid_d   = valid_q;
    idx_d     = idx_q;
    onehot_d  = onehot_q;
    timeout_d = 1'b0;

    rel_done = done[idx_q];
    rel_drop = !req[idx_q];
    rel_to   = HasTimeout && (hold_q == HoldLast);

    unique case (state_q)
      StIdle, StGap: begin
        if (pick_any) begin
          state_d  = StGrant;
          valid_d  = 1'b1;
          idx_d    = pick_idx;
          onehot_d = N'(1) << pick_idx;
          hold_d   = '0;
        end else begin
          state_d  = StIdle;
          valid_d  = 1'b0;
          onehot_d = '0;
        end
      end
      StGrant: begin
        if (rel_done || rel_drop || rel_to) begin
          state_d   = StGap;
          valid_d   = 1'b0;
          onehot_d  = '0;
          ptr_d     = idx_q + 1'b1;
          // A voluntary release on the limit edge is not reported as a timeout.
          timeout_d = rel_to && !rel_done && !rel_drop;
        end else if (hold_q != HoldLast) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d  = StIdle;
        valid_d  = 1'b0;
        onehot_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      hold_q    <= '0;
      valid_q   <= 1'b0;
      idx_q     <= '0;
      onehot_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      valid_q   <= valid_d;
      idx_q     <= idx_d;
      onehot_q  <= onehot_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant_valid  = valid_q;
  assign grant_idx    = idx_q;
  assign grant_onehot = onehot_q;
  assign timeout_evt  = timeout_q;

endmodule
